// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request side, control inputs
// from the pipeline (hold / redirect) and the decode-facing output side.
// The master modport is the fetch queue itself; slave is its environment.
interface fetch_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Instruction-memory request/ready handshake
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic [WIDTH-1:0] imem_data;

    // Pipeline control
    logic             hold;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;

    // Decode-facing valid/ready handshake and status
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic [CW-1:0]    count;
    logic             misaligned;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr, count, misaligned,
        input  imem_ready, imem_data, hold, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, count, misaligned,
        output imem_ready, imem_data, hold, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, requests words from
// instruction memory, buffers up to DEPTH {next_pc, instr} pairs and hands
// them to decode. A redirect flushes the queue and reloads the fetch PC.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               PC_STEP  = 4
) (
    input logic            clk,
    input logic            reset,
    fetch_queue_if.master  bus
);
    localparam int               AW         = $clog2(DEPTH);
    localparam int               CW         = AW + 1;
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);

    // Fetch mode is a pure function of hold; no extra bubble state exists.
    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] next_pc;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             misaligned_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             redirect_misaligned;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    assign mode    = bus.hold ? HELD : RUN;
    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign next_pc = fetch_pc + STEP;   // wraps silently modulo 2^WIDTH

    // Request depends only on registered occupancy, never on out_ready, so a
    // full queue stays silent even when decode pops in the same cycle.
    assign bus.imem_req  = !reset && (mode == RUN) && !bus.redirect && !full;
    assign bus.imem_addr = fetch_pc;

    assign push = bus.imem_req && bus.imem_ready;
    assign pop  = !empty && bus.out_ready;

    assign redirect_misaligned = ((bus.redirect_pc % STEP) != '0);

    // Head entry is forced to zero when empty so stale storage never leaks.
    assign bus.out_valid  = !empty;
    assign bus.out_pc     = empty ? '0 : pc_mem[rd_ptr];
    assign bus.out_instr  = empty ? '0 : instr_mem[rd_ptr];
    assign bus.count      = count_q;
    assign bus.misaligned = misaligned_q;

    // Fetch PC, queue pointers, occupancy and sticky misaligned flag.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect wins over any pop; no push can happen since imem_req=0.
            fetch_pc     <= bus.redirect_pc;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_q      <= '0;
            misaligned_q <= redirect_misaligned;
        end else begin
            if (push) begin
                fetch_pc <= next_pc;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage written at the tail on each transfer.
    // NOTE: storage is deliberately not reset; empty-queue output masking and
    // the pointer reset make its contents unobservable until written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= next_pc;
            instr_mem[wr_ptr] <= bus.imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a negedge monitor keeps a reference
// queue of expected {next_pc, instr} entries and compares every cycle, while
// scenario tasks drive stimulus and check scenario-specific values inline.
module tb_fetch_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic reset;
    logic reset8;

    int total = 0;
    int bad   = 0;

    fetch_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();
    fetch_queue_if #(.WIDTH(8),  .DEPTH(4)) bus8 ();

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_queue #(.WIDTH(8), .DEPTH(4), .RESET_PC(8'h0), .PC_STEP(4)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8)
    );

    // Instruction memory contents: fixed hash of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [7:0] word8(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    assign bus.imem_data  = word(bus.imem_addr);
    assign bus8.imem_data = word8(bus8.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model state for the 32-bit instance.
    entry_t      sb [$];
    logic [31:0] m_pc;
    logic        m_mis;
    logic        m_req;

    // Compare the DUT against the model away from the edge, then advance the
    // model by what the coming rising edge must do.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_pc  = 32'h0;
            m_mis = 1'b0;
            total++;
            if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0 ||
                bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.misaligned !== 1'b0 ||
                bus.imem_addr !== 32'h0) begin
                bad++;
                $display("FAIL mon_reset: req=%b valid=%b count=%0d pc=%h instr=%h mis=%b addr=%h, all want 0",
                         bus.imem_req, bus.out_valid, bus.count, bus.out_pc, bus.out_instr,
                         bus.misaligned, bus.imem_addr);
            end
        end else begin
            m_req = !bus.hold && !bus.redirect && (sb.size() < 4);
            total++;
            if (bus.imem_req !== m_req) begin
                bad++;
                $display("FAIL mon_req: got %b want %b at %0t", bus.imem_req, m_req, $time);
            end
            total++;
            if (bus.imem_addr !== m_pc) begin
                bad++;
                $display("FAIL mon_addr: got %h want %h at %0t", bus.imem_addr, m_pc, $time);
            end
            total++;
            if (bus.count !== 3'(sb.size())) begin
                bad++;
                $display("FAIL mon_count: got %0d want %0d at %0t", bus.count, sb.size(), $time);
            end
            total++;
            if (bus.misaligned !== m_mis) begin
                bad++;
                $display("FAIL mon_mis: got %b want %b at %0t", bus.misaligned, m_mis, $time);
            end
            total++;
            if (sb.size() != 0) begin
                if (bus.out_valid !== 1'b1 || bus.out_pc !== sb[0].pc || bus.out_instr !== sb[0].instr) begin
                    bad++;
                    $display("FAIL mon_head: got v=%b %h/%h want v=1 %h/%h at %0t",
                             bus.out_valid, bus.out_pc, bus.out_instr, sb[0].pc, sb[0].instr, $time);
                end
            end else begin
                if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
                    bad++;
                    $display("FAIL mon_empty: got v=%b %h/%h want v=0 0/0 at %0t",
                             bus.out_valid, bus.out_pc, bus.out_instr, $time);
                end
            end
            if (bus.redirect) begin
                sb.delete();
                m_pc  = bus.redirect_pc;
                m_mis = ((bus.redirect_pc % 32'd4) != 32'd0);
            end else begin
                if (sb.size() != 0 && bus.out_ready) void'(sb.pop_front());
                if (m_req && bus.imem_ready) begin
                    sb.push_back({m_pc + 32'd4, word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Advance to 2 time units after the n-th next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.imem_req !== 1'b0 ||
            bus.imem_addr !== 32'h0 || bus.out_pc !== 32'h0 || bus.misaligned !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b count=%0d req=%b addr=%h pc=%h mis=%b want all 0",
                     bus.out_valid, bus.count, bus.imem_req, bus.imem_addr, bus.out_pc, bus.misaligned);
        end
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        #1;
        total++;
        if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_start: addr=%h req=%b valid=%b want 0/1/0",
                     bus.imem_addr, bus.imem_req, bus.out_valid);
        end
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            #1;
            total++;
            if (bus.imem_addr !== 32'(4 * i) || bus.out_pc !== 32'(4 * i) ||
                bus.out_instr !== word(32'(4 * (i - 1))) || bus.count !== 3'd1) begin
                bad++;
                $display("FAIL stream_%0d: addr=%h pc=%h instr=%h count=%0d want %h/%h/%h/1", i,
                         bus.imem_addr, bus.out_pc, bus.out_instr, bus.count,
                         32'(4 * i), 32'(4 * i), word(32'(4 * (i - 1))));
            end
        end
    endtask

    task automatic test_full();
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        tick(1);
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.count !== 3'd0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL full_restart: count=%0d addr=%h req=%b want 0/0/1",
                     bus.count, bus.imem_addr, bus.imem_req);
        end
        tick(4);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.count !== 3'd4 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd16 ||
                bus.out_pc !== 32'd4 || bus.out_instr !== word(32'd0)) begin
                bad++;
                $display("FAIL full_stall_%0d: count=%0d req=%b addr=%h pc=%h instr=%h want 4/0/10/4/%h",
                         i, bus.count, bus.imem_req, bus.imem_addr, bus.out_pc, bus.out_instr, word(32'd0));
            end
            tick(1);
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_noreq: got req=%b want 0", bus.imem_req);
        end
        tick(1);
        bus.out_ready = 1'b0;
        #1;
        total++;
        if (bus.count !== 3'd3 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd16 ||
            bus.out_pc !== 32'd8 || bus.out_instr !== word(32'd4)) begin
            bad++;
            $display("FAIL full_after_pop: count=%0d req=%b addr=%h pc=%h want 3/1/10/8",
                     bus.count, bus.imem_req, bus.imem_addr, bus.out_pc);
        end
        tick(1);
        #1;
        total++;
        if (bus.count !== 3'd4 || bus.imem_addr !== 32'd20 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_refill: count=%0d addr=%h req=%b want 4/14/0",
                     bus.count, bus.imem_addr, bus.imem_req);
        end
    endtask

    task automatic test_redirect_flush();
        bus.out_ready = 1'b1;
        tick(1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        #1;
        total++;
        if (bus.count !== 3'd3 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL flush_before: count=%0d req=%b want 3/0", bus.count, bus.imem_req);
        end
        tick(1);
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100 ||
            bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL flush_after: count=%0d valid=%b addr=%h req=%b want 0/0/100/1",
                     bus.count, bus.out_valid, bus.imem_addr, bus.imem_req);
        end
        tick(1);
        #1;
        total++;
        if (bus.out_pc !== 32'h104 || bus.out_instr !== word(32'h100) || bus.count !== 3'd1) begin
            bad++;
            $display("FAIL flush_first: pc=%h instr=%h count=%0d want 104/%h/1",
                     bus.out_pc, bus.out_instr, bus.count, word(32'h100));
        end
    endtask

    task automatic test_misaligned();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        tick(1);
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.misaligned !== 1'b1 || bus.imem_addr !== 32'h102 || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL mis_set: mis=%b addr=%h req=%b want 1/102/1",
                     bus.misaligned, bus.imem_addr, bus.imem_req);
        end
        tick(1);
        #1;
        total++;
        if (bus.out_pc !== 32'h106 || bus.out_instr !== word(32'h102) || bus.misaligned !== 1'b1) begin
            bad++;
            $display("FAIL mis_fetch: pc=%h instr=%h mis=%b want 106/%h/1",
                     bus.out_pc, bus.out_instr, bus.misaligned, word(32'h102));
        end
        tick(2);
        #1;
        total++;
        if (bus.misaligned !== 1'b1) begin
            bad++;
            $display("FAIL mis_sticky: got %b want 1", bus.misaligned);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick(1);
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.misaligned !== 1'b0 || bus.imem_addr !== 32'h200) begin
            bad++;
            $display("FAIL mis_clear: mis=%b addr=%h want 0/200", bus.misaligned, bus.imem_addr);
        end
    endtask

    task automatic test_hold();
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        tick(1);
        bus.redirect = 1'b0;
        tick(2);
        bus.hold      = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.imem_req !== 1'b0 || bus.count !== 3'd2 || bus.imem_addr !== 32'h308) begin
            bad++;
            $display("FAIL hold_enter: req=%b count=%0d addr=%h want 0/2/308",
                     bus.imem_req, bus.count, bus.imem_addr);
        end
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            #1;
            total++;
            if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h308 ||
                bus.count !== ((k >= 2) ? 3'd0 : 3'(2 - k))) begin
                bad++;
                $display("FAIL hold_cycle_%0d: req=%b addr=%h count=%0d want 0/308/%0d",
                         k, bus.imem_req, bus.imem_addr, bus.count, (k >= 2) ? 0 : 2 - k);
            end
        end
        bus.hold = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h308) begin
            bad++;
            $display("FAIL hold_release: req=%b addr=%h want 1/308", bus.imem_req, bus.imem_addr);
        end
        tick(1);
        #1;
        total++;
        if (bus.out_pc !== 32'h30C || bus.out_instr !== word(32'h308) || bus.count !== 3'd1) begin
            bad++;
            $display("FAIL hold_resume: pc=%h instr=%h count=%0d want 30c/%h/1",
                     bus.out_pc, bus.out_instr, bus.count, word(32'h308));
        end
    endtask

    task automatic test_back_to_back();
        bus.hold        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h400;
        tick(1);
        bus.hold        = 1'b0;
        bus.redirect_pc = 32'h500;
        #1;
        total++;
        if (bus.imem_addr !== 32'h400 || bus.count !== 3'd0 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: addr=%h count=%0d req=%b want 400/0/0",
                     bus.imem_addr, bus.count, bus.imem_req);
        end
        tick(1);
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.imem_addr !== 32'h500 || bus.imem_req !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_last: addr=%h req=%b valid=%b want 500/1/0",
                     bus.imem_addr, bus.imem_req, bus.out_valid);
        end
        tick(1);
        #1;
        total++;
        if (bus.out_pc !== 32'h504) begin
            bad++;
            $display("FAIL b2b_out: pc=%h want 504", bus.out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'hF8;
        exp_addr[1] = 8'hFC;
        exp_addr[2] = 8'h00;
        exp_addr[3] = 8'h04;
        bus8.imem_ready  = 1'b1;
        bus8.out_ready   = 1'b1;
        bus8.redirect    = 1'b1;
        bus8.redirect_pc = 8'hF8;
        reset8           = 1'b0;
        tick(1);
        bus8.redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus8.imem_addr !== exp_addr[i] || bus8.imem_req !== 1'b1) begin
                bad++;
                $display("FAIL wrap_addr_%0d: addr=%h req=%b want %h/1",
                         i, bus8.imem_addr, bus8.imem_req, exp_addr[i]);
            end
            if (i > 0) begin
                total++;
                if (bus8.out_pc !== exp_addr[i] || bus8.out_instr !== word8(exp_addr[i-1])) begin
                    bad++;
                    $display("FAIL wrap_out_%0d: pc=%h instr=%h want %h/%h",
                             i, bus8.out_pc, bus8.out_instr, exp_addr[i], word8(exp_addr[i-1]));
                end
            end
            tick(1);
        end
        #1;
        reset8 = 1'b1;
        #1;
        total++;
        if (bus8.out_valid !== 1'b0 || bus8.out_pc !== 8'h0 || bus8.out_instr !== 8'h0 ||
            bus8.count !== 3'd0 || bus8.imem_req !== 1'b0 || bus8.imem_addr !== 8'h0 ||
            bus8.misaligned !== 1'b0) begin
            bad++;
            $display("FAIL wrap_async_reset: valid=%b pc=%h instr=%h count=%0d req=%b addr=%h mis=%b want all 0",
                     bus8.out_valid, bus8.out_pc, bus8.out_instr, bus8.count, bus8.imem_req,
                     bus8.imem_addr, bus8.misaligned);
        end
        tick(1);
        reset8 = 1'b0;
        #1;
        total++;
        if (bus8.imem_addr !== 8'h0 || bus8.imem_req !== 1'b1 || bus8.count !== 3'd0) begin
            bad++;
            $display("FAIL wrap_restart: addr=%h req=%b count=%0d want 0/1/0",
                     bus8.imem_addr, bus8.imem_req, bus8.count);
        end
        tick(1);
        #1;
        total++;
        if (bus8.out_pc !== 8'h4 || bus8.out_instr !== word8(8'h0)) begin
            bad++;
            $display("FAIL wrap_first: pc=%h instr=%h want 04/%h", bus8.out_pc, bus8.out_instr, word8(8'h0));
        end
    endtask

    initial begin
        reset            = 1'b1;
        reset8           = 1'b1;
        bus.imem_ready   = 1'b1;
        bus.hold         = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus.out_ready    = 1'b1;
        bus8.imem_ready  = 1'b0;
        bus8.hold        = 1'b0;
        bus8.redirect    = 1'b0;
        bus8.redirect_pc = 8'h0;
        bus8.out_ready   = 1'b0;

        test_reset();
        test_stream();
        test_full();
        test_redirect_flush();
        test_misaligned();
        test_hold();
        test_back_to_back();
        test_wrap();

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the fixed PC register, PC adder and IF/ID flipflop.
- Owns the fetch PC and issues requests to instruction memory over a req/ready handshake.
- Buffers up to DEPTH fetched {next_pc, instr} pairs in a FIFO.
- Presents them to decode over a valid/ready handshake; branch/jump redirects flush the queue.

Parameters:
WIDTH, 32, data and address width in bits
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch address (current fetch PC)
imem_ready  input  1  memory accepts request; imem_data valid this cycle
imem_data  input  WIDTH  fetched instruction word
hold  input  1  freeze fetch; no new requests, queue still drains
redirect  input  1  branch/jump taken; flush and restart
redirect_pc  input  WIDTH  new fetch PC when redirect=1
out_valid  output  1  head entry valid
out_ready  input  1  decode accepts head entry
out_pc  output  WIDTH  head entry: instruction PC + PC_STEP
out_instr  output  WIDTH  head entry: instruction word
count  output  $clog2(DEPTH)+1  occupied entries
misaligned  output  1  sticky: last redirect_pc not a multiple of PC_STEP

Behaviour:
- Reset (asynchronous, active-high; clk and reset named as everywhere else in the CPU):
  - While asserted: fetch PC = RESET_PC, queue empty, count=0, out_valid=0, out_pc=0, out_instr=0, misaligned=0, imem_req=0.
  - Reset mid-transfer discards the transfer; no partial state survives.
- State: fetch PC register plus FIFO storage (read pointer, write pointer, count). States RUN and HELD, selected by hold; there is no hidden bubble state.
- imem_addr = fetch PC, always.
- imem_req = !reset && !hold && !redirect && (count < DEPTH).
  - No combinational path from out_ready to imem_req: a full queue does not request even if a pop occurs the same cycle.
- Transfer (push): imem_req && imem_ready at a rising edge.
  - Pushes {fetch PC + PC_STEP, imem_data} at the tail.
  - Fetch PC advances by PC_STEP, modulo 2^WIDTH; wrap from all-ones region to 0 is silent.
- Pop: out_valid && out_ready at a rising edge removes the head entry.
- Outputs: out_valid = (count != 0). out_pc/out_instr show the head entry when valid, 0 when empty.
  - Decode sees the first instruction one cycle after its transfer (1-cycle latency).
  - out_pc/out_instr must hold stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged. A pop from a full queue does not enable a push that cycle.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH. count never exceeds DEPTH and never underflows; pop on empty is impossible since out_valid=0.
- Redirect has priority over everything at the edge:
  - Queue flushed (count=0, pointers reset); a concurrent pop is a no-op.
  - Fetch PC <= redirect_pc; no transfer occurs, since imem_req=0 while redirect=1.
  - misaligned <= (redirect_pc mod PC_STEP != 0).
  - Next cycle: out_valid=0, and a request to redirect_pc is issued if hold=0.
- Misaligned redirect still fetches from redirect_pc unchanged. misaligned stays set until an aligned redirect or reset.
- hold=1: imem_req=0 and fetch PC frozen; pops continue. redirect while hold=1 still flushes and reloads the PC.
- Back-to-back redirects: each is applied in turn; the last one wins.

Test Plan:
1. Reset release, RESET_PC=0, imem_ready=1 always, out_ready=1 → imem_addr sequence 0,4,8,…; out_pc 4,8,12… one cycle behind, out_instr matches memory words; count stays 1.
2. out_ready=0, imem_ready=1, DEPTH=4 → four pushes, then count=4, imem_req=0, fetch PC=16. One pop then gives count=3 and a request for 16 next cycle; head stays stable throughout stall.
3. Queue holding 3 entries, redirect=1 with redirect_pc=0x100 and out_ready=1 the same cycle → next cycle count=0, out_valid=0, imem_addr=0x100, imem_req=1. First instruction emerges with out_pc=0x104.
4. redirect_pc=0x102 → misaligned=1 and fetch from 0x102. A later redirect to 0x200 clears misaligned.
5. hold=1 for 5 cycles with 2 entries queued, out_ready=1 → no requests, queue drains to 0, imem_addr frozen. On release, fetch resumes at the frozen PC.
6. WIDTH=8, start near 0xF8, continuous fetch → addresses 0xF8,0xFC,0x00,0x04. Assert reset mid-run → all outputs zero immediately (asynchronous), then fetch restarts at RESET_PC.
